// File: rtl/riscy_pkg.sv
// Shared types and encodings for the riscy32 control path: sequencer states,
// RV32I opcodes, ALU operation codes and datapath mux selects.
package riscy_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // ALU codes are {funct7[5], funct3}; PASSB sits in an otherwise unused slot
    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h8;
    localparam logic [3:0] ALU_PASSB = 4'hF;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_SRX  = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_U = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_B = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/control_multi_if.sv
// Bundle between the multicycle sequencer and the datapath/memory side:
// decoded instruction fields and flags in, enables and mux selects out.
interface control_multi_if #(
    parameter int ALU_W = 4
);
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7;
    logic [3:0]       flags;
    logic             mem_ready;
    logic             PCWrite;
    logic             AdrSrc;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             RegWrite;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ImmSrc;
    logic [ALU_W-1:0] ALUControl;
    logic             illegal;
    logic [3:0]       state_dbg;

    modport master (
        output op, funct3, funct7, flags, mem_ready,
        input  PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, state_dbg
    );

    modport slave (
        input  op, funct3, funct7, flags, mem_ready,
        output PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, state_dbg
    );
endinterface

// File: rtl/branch_unit.sv
// Branch condition resolver: turns funct3 and the ALU {N,Z,C,V} flags of
// rs1 - rs2 into a taken/not-taken decision.
module branch_unit
    import riscy_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [3:0] flags,
    output logic       take
);
    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    // C is the no-borrow carry of rs1 - rs2, so unsigned less-than is !C
    always_comb begin
        take = 1'b0;
        case (funct3)
            F3_BEQ:  take = z;
            F3_BNE:  take = !z;
            F3_BLT:  take = n ^ v;
            F3_BGE:  take = !(n ^ v);
            F3_BLTU: take = !c;
            F3_BGEU: take = c;
            default: take = 1'b0;
        endcase
    end
endmodule

// File: rtl/control_multi.sv
// Multicycle RV32I sequencer: walks each instruction through fetch, decode,
// execute, memory and writeback over a shared memory port.
module control_multi
    import riscy_pkg::*;
#(
    parameter int ALU_W           = 4,
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    control_multi_if.slave bus
);
    state_e state_reg, state_next;
    logic   take;
    logic   ready;

    assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    branch_unit u_branch (
        .funct3 (bus.funct3),
        .flags  (bus.flags),
        .take   (take)
    );

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_FETCH;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next     = state_reg;
        bus.PCWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ResultSrc  = RES_ALUOUT;
        bus.ALUSrcA    = SRCA_PC;
        bus.ALUSrcB    = SRCB_RS2;
        bus.ImmSrc     = IMM_I;
        bus.ALUControl = ALU_W'(ALU_ADD);
        bus.illegal    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                bus.MemRead   = 1'b1;
                bus.IRWrite   = ready;
                bus.PCWrite   = ready;
                bus.ALUSrcA   = SRCA_PC;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
                if (ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                // branch target is computed speculatively into ALUOut
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc  = IMM_B;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_JAL:            state_next = S_JAL;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_LUI:            state_next = S_LUI;
                    default:           state_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc  = (bus.op == OP_LOAD) ? IMM_I : IMM_S;
                state_next  = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.MemRead = 1'b1;
                bus.AdrSrc  = 1'b1;
                if (ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                bus.RegWrite  = 1'b1;
                state_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.MemWrite = 1'b1;
                bus.AdrSrc   = 1'b1;
                if (ready) state_next = S_FETCH;
            end
            S_EXECR: begin
                bus.ALUSrcA    = SRCA_RS1;
                bus.ALUSrcB    = SRCB_RS2;
                bus.ALUControl = ALU_W'({bus.funct7, bus.funct3});
                state_next     = S_ALUWB;
            end
            S_EXECI: begin
                // funct7[5] only distinguishes srai/srli; for addi etc. it is immediate bits
                bus.ALUSrcA    = SRCA_RS1;
                bus.ALUSrcB    = SRCB_IMM;
                bus.ImmSrc     = IMM_I;
                bus.ALUControl = (bus.funct3 == F3_SRX) ? ALU_W'({bus.funct7, bus.funct3})
                                                        : ALU_W'({1'b0, bus.funct3});
                state_next     = S_ALUWB;
            end
            S_ALUWB: begin
                bus.ResultSrc = RES_ALUOUT;
                bus.RegWrite  = 1'b1;
                state_next    = S_FETCH;
            end
            S_JAL: begin
                bus.ALUSrcA   = SRCA_OLDPC;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ImmSrc    = IMM_J;
                bus.ResultSrc = RES_ALUOUT;
                bus.PCWrite   = 1'b1;
                state_next    = S_ALUWB;
            end
            S_LUI: begin
                bus.ImmSrc     = IMM_U;
                bus.ALUSrcB    = SRCB_IMM;
                bus.ALUControl = ALU_W'(ALU_PASSB);
                state_next     = S_ALUWB;
            end
            S_BRANCH: begin
                bus.ALUSrcA    = SRCA_RS1;
                bus.ALUSrcB    = SRCB_RS2;
                bus.ALUControl = ALU_W'(ALU_SUB);
                bus.ResultSrc  = RES_ALUOUT;
                bus.PCWrite    = take;
                state_next     = S_FETCH;
            end
            S_TRAP: begin
                bus.illegal = 1'b1;
                state_next  = S_TRAP;
            end
            default: state_next = S_FETCH;
        endcase
        // an aborted instruction must not commit anything in the reset cycle
        if (rst) begin
            bus.PCWrite  = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.RegWrite = 1'b0;
            bus.MemWrite = 1'b0;
        end
    end

    assign bus.state_dbg = state_reg;
endmodule

// File: tb/tb_control_multi.sv
// Scoreboarded random bench for control_multi: the stimulus side expands each
// instruction into its cycle-by-cycle expected outputs, a monitor compares them.
module tb_control_multi;
    import riscy_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, mrd, mwr, irw, rgw;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       ill;
    } obs_t;

    typedef struct packed {
        int   id;
        obs_t a;
        obs_t b;
    } item_t;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4, K_LUI = 5, K_BR = 6, K_ILL = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic [3:0] flags;
    logic       mem_ready;

    int    checks = 0;
    int    failures = 0;
    int    step_no = 0;
    item_t q[$];
    obs_t  obs_a, obs_b;

    always #5 clk = ~clk;

    control_multi_if #(.ALU_W(4)) ifa ();
    control_multi_if #(.ALU_W(4)) ifb ();

    assign {ifa.op, ifa.funct3, ifa.funct7, ifa.flags, ifa.mem_ready} = {op, funct3, funct7, flags, mem_ready};
    assign {ifb.op, ifb.funct3, ifb.funct7, ifb.flags, ifb.mem_ready} = {op, funct3, funct7, flags, mem_ready};

    control_multi #(.ALU_W(4), .MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave)
    );
    control_multi #(.ALU_W(4), .MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave)
    );

    assign obs_a = {ifa.state_dbg, ifa.PCWrite, ifa.AdrSrc, ifa.MemRead, ifa.MemWrite, ifa.IRWrite,
                    ifa.RegWrite, ifa.ResultSrc, ifa.ALUSrcA, ifa.ALUSrcB, ifa.ImmSrc, ifa.ALUControl, ifa.illegal};
    assign obs_b = {ifb.state_dbg, ifb.PCWrite, ifb.AdrSrc, ifb.MemRead, ifb.MemWrite, ifb.IRWrite,
                    ifb.RegWrite, ifb.ResultSrc, ifb.ALUSrcA, ifb.ALUSrcB, ifb.ImmSrc, ifb.ALUControl, ifb.illegal};

    function automatic logic branch_taken(input logic [2:0] f3, input logic [3:0] fl);
        logic n, z, c, v;
        {n, z, c, v} = fl;
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return n != v;
            3'b101:  return n == v;
            3'b110:  return !c;
            3'b111:  return c;
            default: return 1'b0;
        endcase
    endfunction

    // Expected control word for one phase of an instruction
    function automatic obs_t model(input state_e ph, input logic [6:0] o, input logic [2:0] f3,
                                   input logic f7, input logic [3:0] fl, input logic rdy, input logic r);
        obs_t e = '0;
        e.st = ph;
        case (ph)
            S_FETCH:    begin e.mrd = 1; e.irw = rdy; e.pcw = rdy; e.sb = 2'b10; e.rs = 2'b10; end
            S_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; e.imm = 3'b100; end
            S_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; e.imm = (o == 7'b0000011) ? 3'b000 : 3'b001; end
            S_MEMREAD:  begin e.mrd = 1; e.adr = 1; end
            S_MEMWB:    begin e.rs = 2'b01; e.rgw = 1; end
            S_MEMWRITE: begin e.mwr = 1; e.adr = 1; end
            S_EXECR:    begin e.sa = 2'b10; e.alu = {f7, f3}; end
            S_EXECI:    begin e.sa = 2'b10; e.sb = 2'b01; e.alu = (f3 == 3'b101) ? {f7, f3} : {1'b0, f3}; end
            S_ALUWB:    begin e.rgw = 1; end
            S_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; e.imm = 3'b011; end
            S_LUI:      begin e.imm = 3'b010; e.sb = 2'b01; e.alu = 4'hF; end
            S_BRANCH:   begin e.sa = 2'b10; e.alu = 4'h8; e.pcw = branch_taken(f3, fl); end
            S_TRAP:     begin e.ill = 1; end
            default:    ;
        endcase
        if (r) begin e.pcw = 0; e.irw = 0; e.rgw = 0; e.mwr = 0; end
        return e;
    endfunction

    task automatic step(input state_e pa, input state_e pb, input logic rdy, input logic r);
        item_t it;
        mem_ready = rdy;
        rst       = r;
        it.id = step_no;
        it.a  = model(pa, op, funct3, funct7, flags, rdy, r);
        it.b  = model(pb, op, funct3, funct7, flags, rdy, r);
        q.push_back(it);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into its phases; mem_ready is random where it must be ignored
    task automatic run_instr(input int kind, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic [3:0] fl, input int wf, input int wm, input bit abort);
        int start = step_no;
        for (int i = 0; i < wf; i++) begin
            op = 7'($urandom); funct3 = 3'($urandom); flags = 4'($urandom);
            step(S_FETCH, S_FETCH, 1'b0, 1'b0);
        end
        step(S_FETCH, S_FETCH, 1'b1, 1'b0);
        op = o; funct3 = f3; funct7 = f7; flags = fl;
        step(S_DECODE, S_DECODE, rnd_bit(), 1'b0);
        case (kind)
            K_LW: begin
                step(S_MEMADR, S_MEMADR, rnd_bit(), 1'b0);
                for (int i = 0; i < wm; i++) step(S_MEMREAD, S_MEMREAD, 1'b0, 1'b0);
                step(S_MEMREAD, S_MEMREAD, 1'b1, 1'b0);
                step(S_MEMWB, S_MEMWB, rnd_bit(), 1'b0);
            end
            K_SW: begin
                step(S_MEMADR, S_MEMADR, rnd_bit(), 1'b0);
                for (int i = 0; i < wm; i++) step(S_MEMWRITE, S_MEMWRITE, 1'b0, 1'b0);
                if (abort) step(S_MEMWRITE, S_MEMWRITE, rnd_bit(), 1'b1);
                else       step(S_MEMWRITE, S_MEMWRITE, 1'b1, 1'b0);
            end
            K_R:   begin step(S_EXECR, S_EXECR, rnd_bit(), 1'b0); step(S_ALUWB, S_ALUWB, rnd_bit(), 1'b0); end
            K_I:   begin step(S_EXECI, S_EXECI, rnd_bit(), 1'b0); step(S_ALUWB, S_ALUWB, rnd_bit(), 1'b0); end
            K_JAL: begin step(S_JAL, S_JAL, rnd_bit(), 1'b0);     step(S_ALUWB, S_ALUWB, rnd_bit(), 1'b0); end
            K_LUI: begin step(S_LUI, S_LUI, rnd_bit(), 1'b0);     step(S_ALUWB, S_ALUWB, rnd_bit(), 1'b0); end
            K_BR:  step(S_BRANCH, S_BRANCH, rnd_bit(), 1'b0);
            default: begin
                // the trapping core stays put; the non-trapping one keeps refetching the same op
                for (int i = 0; i < 10; i++)
                    step(S_TRAP, (i % 2 == 0) ? S_FETCH : S_DECODE, 1'b1, 1'b0);
                step(S_TRAP, S_FETCH, 1'b1, 1'b1);
            end
        endcase
        $display("txn kind=%0d op=%b f3=%b f7=%b flags=%b cycles=%0d", kind, o, f3, f7, fl, step_no - start);
    endtask

    function automatic logic [6:0] opcode_of(input int kind);
        logic [6:0] o;
        case (kind)
            K_LW:  o = 7'b0000011;
            K_SW:  o = 7'b0100011;
            K_R:   o = 7'b0110011;
            K_I:   o = 7'b0010011;
            K_JAL: o = 7'b1101111;
            K_LUI: o = 7'b0110111;
            K_BR:  o = 7'b1100011;
            default: begin
                do o = 7'($urandom);
                while (o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1101111, 7'b0110111, 7'b1100011});
            end
        endcase
        return o;
    endfunction

    always @(negedge clk) begin
        item_t it;
        if (q.size() > 0) begin
            it = q.pop_front();
            checks++;
            if (obs_a !== it.a) begin
                failures++;
                $display("FAIL ctrl_trap step=%0d state got=%0d exp=%0d word got=%h exp=%h",
                         it.id, obs_a.st, it.a.st, obs_a, it.a);
            end
            checks++;
            if (obs_b !== it.b) begin
                failures++;
                $display("FAIL ctrl_notrap step=%0d state got=%0d exp=%0d word got=%h exp=%h",
                         it.id, obs_b.st, it.b.st, obs_b, it.b);
            end
        end
    end

    initial begin
        int kind;
        rst = 1'b1; op = '0; funct3 = '0; funct7 = 1'b0; flags = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // sub, lw with two memory stalls, then the branch sweep
        run_instr(K_R,  7'b0110011, 3'b000, 1'b1, 4'b0000, 0, 0, 1'b0);
        run_instr(K_LW, 7'b0000011, 3'b010, 1'b0, 4'b0000, 0, 2, 1'b0);
        run_instr(K_BR, 7'b1100011, 3'b000, 1'b0, 4'b0100, 0, 0, 1'b0);
        run_instr(K_BR, 7'b1100011, 3'b001, 1'b0, 4'b0100, 0, 0, 1'b0);
        run_instr(K_BR, 7'b1100011, 3'b100, 1'b0, 4'b1000, 0, 0, 1'b0);
        run_instr(K_BR, 7'b1100011, 3'b101, 1'b0, 4'b1000, 0, 0, 1'b0);
        run_instr(K_BR, 7'b1100011, 3'b110, 1'b0, 4'b0000, 0, 0, 1'b0);
        run_instr(K_BR, 7'b1100011, 3'b111, 1'b0, 4'b0000, 0, 0, 1'b0);
        run_instr(K_BR, 7'b1100011, 3'b010, 1'b0, 4'b1111, 0, 0, 1'b0);
        run_instr(K_SW, 7'b0100011, 3'b010, 1'b0, 4'b0000, 0, 1, 1'b1);
        run_instr(K_ILL, 7'b1111111, 3'b000, 1'b0, 4'b0000, 0, 0, 1'b0);
        run_instr(K_JAL, 7'b1101111, 3'b000, 1'b0, 4'b0000, 0, 0, 1'b0);
        run_instr(K_LUI, 7'b0110111, 3'b000, 1'b0, 4'b0000, 0, 0, 1'b0);
        run_instr(K_I,  7'b0010011, 3'b101, 1'b1, 4'b0000, 1, 0, 1'b0);
        run_instr(K_I,  7'b0010011, 3'b000, 1'b1, 4'b0000, 0, 0, 1'b0);
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 7);
            run_instr(kind, opcode_of(kind), 3'($urandom), 1'($urandom), 4'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
